// File: rtl/seq_adder_pkg.sv
// ============================================================================
// Module   : seq_adder_pkg
// Brief    : Shared types and constants for the bit-serial adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seq_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Operand register input select: parallel load vs. shift right
    localparam logic SEL_LOAD  = 1'b1;
    localparam logic SEL_SHIFT = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_fa_bit.sv
// ============================================================================
// Module   : seq_fa_bit
// Brief    : Combinational 1-bit full adder used by the serial datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

`default_nettype wire

// File: rtl/seq_adder_ctrl.sv
// ============================================================================
// Module   : seq_adder_ctrl
// Brief    : Bit-serial adder: loads two operands, adds one bit per clock,
//            returns sum/cout with a one-cycle done pulse.
//            Define SEQ_ADDER_CTRL_SUB_EN to add the 'sub' port (a - b).
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_adder_ctrl
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SEQ_ADDER_CTRL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_sel;
    logic [WIDTH-1:0] w_b_load;
    logic             w_cin_load;
    logic [WIDTH-1:0] w_a_shift;
    logic [WIDTH-1:0] w_b_shift;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic [WIDTH-1:0] w_sum_next;
    logic             w_s;
    logic             w_co;

`ifdef SEQ_ADDER_CTRL_SUB_EN
    // Subtraction as a + ~b + 1; cout=1 means no borrow
    assign w_b_load   = sub ? ~b : b;
    assign w_cin_load = sub ? 1'b1 : cin;
`else
    assign w_b_load   = b;
    assign w_cin_load = cin;
`endif

    assign w_sel     = (r_state == SHIFT) ? SEL_SHIFT : SEL_LOAD;
    assign w_a_shift = {1'b0, r_a_sr[WIDTH-1:1]};
    assign w_b_shift = {1'b0, r_b_sr[WIDTH-1:1]};

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_sel_mux
            assign w_a_next[i] = (w_sel == SEL_LOAD) ? a[i]        : w_a_shift[i];
            assign w_b_next[i] = (w_sel == SEL_LOAD) ? w_b_load[i] : w_b_shift[i];
        end
    endgenerate

    seq_fa_bit u_fa (
        .a  (r_a_sr[0]),
        .b  (r_b_sr[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // Sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts
    assign w_sum_next = {w_s, r_sum_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a_sr  <= w_a_next;
                        r_b_sr  <= w_b_next;
                        r_carry <= w_cin_load;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_a_sr   <= w_a_next;
                    r_b_sr   <= w_b_next;
                    r_carry  <= w_co;
                    r_sum_sr <= w_sum_next;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_last_cnt) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_sum   <= w_sum_next;
                        r_cout  <= w_co;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

`default_nettype wire
